// File: rtl/ifetch_prefetch.sv
// Instruction prefetch: owns the PC, streams in-order requests to instruction memory
// and buffers returned words (tagged with their PC) for the fetch stage.
module ifetch_prefetch #(
  parameter int              PC_W     = 8,
  parameter int              OP_W     = 16,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [OP_W-1:0]            imem_rdata,
  output logic                       op_valid,
  output logic [OP_W-1:0]            op_out,
  output logic [PC_W-1:0]            op_pc,
  input  logic                       op_ready,
  output logic [$clog2(DEPTH):0]     fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [PC_W-1:0] pc;
  } entry_t;

  logic [PC_W-1:0]      pc, rsp_pc;
  logic [CW-1:0]        count, inflight, drop_cnt;
  logic [AW-1:0]        rd_ptr, wr_ptr;
  entry_t [DEPTH-1:0]   fifo_q;

  logic [CW:0] occ_sum, out_sum;
  logic        grant, push, pop, drop, rsp_consumed;

  // Credits: FIFO space must cover every live request, and stale responses
  // still owed by memory bound how far ahead we may run.
  assign occ_sum  = {1'b0, count}    + {1'b0, inflight};
  assign out_sum  = {1'b0, inflight} + {1'b0, drop_cnt};
  assign imem_req = !reset && !redirect &&
                    (occ_sum < (CW+1)'(DEPTH)) && (out_sum < (CW+1)'(DEPTH));
  assign imem_addr = pc;

  assign grant = imem_req && imem_gnt;
  assign drop  = imem_rvalid && (drop_cnt != '0);
  assign push  = imem_rvalid && (drop_cnt == '0) && (inflight != '0) && !redirect;
  assign pop   = op_valid && op_ready;
  // A redirect-cycle response only retires a credit if one is actually owed.
  assign rsp_consumed = imem_rvalid && ((drop_cnt != '0) || (inflight != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      rsp_pc   <= redirect_pc;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= drop_cnt + inflight - CW'(rsp_consumed);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (grant) pc <= pc + 1'b1;
      if (push) begin
        rsp_pc <= rsp_pc + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      inflight <= inflight + CW'(grant) - CW'(push);
      drop_cnt <= drop_cnt - CW'(drop);
      count    <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: reads are gated by op_valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{op: imem_rdata, pc: rsp_pc};
  end

  assign op_valid   = (count != '0);
  assign op_out     = op_valid ? fifo_q[rd_ptr].op : '0;
  assign op_pc      = op_valid ? fifo_q[rd_ptr].pc : '0;
  assign fifo_count = count;
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: bench-side memory with configurable latency,
// a queue-based reference model checked every cycle, plus literal spot checks.
module tb_ifetch_prefetch;
  localparam int PC_W = 8, OP_W = 16, DEPTH = 4, CW = 3;

  logic clk = 1'b0;
  logic reset, redirect, imem_gnt, imem_rvalid, op_ready, imem_req, op_valid;
  logic [PC_W-1:0] redirect_pc, imem_addr, op_pc;
  logic [OP_W-1:0] imem_rdata, op_out;
  logic [CW-1:0]   fifo_count;

  always #5 clk = ~clk;

  ifetch_prefetch #(.PC_W(PC_W), .OP_W(OP_W), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .op_valid(op_valid), .op_out(op_out), .op_pc(op_pc), .op_ready(op_ready),
    .fifo_count(fifo_count)
  );

  typedef struct { logic [PC_W-1:0] addr; bit stale; } ost_t;
  typedef struct { logic [OP_W-1:0] op; logic [PC_W-1:0] pc; } ent_t;
  typedef struct { logic [PC_W-1:0] addr; int due; } mreq_t;

  ost_t  oq[$];   // model: requests still owed by memory, oldest first
  ent_t  fq[$];   // model: words visible to the fetch stage
  mreq_t mq[$];   // bench memory: granted requests awaiting response
  logic [PC_W-1:0] m_pc;
  int  cyc = 0, lat = 1;
  int  n_pass = 0, n_chk = 0;
  bit  stray = 1'b0, mem_drv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int nlive();
    int n = 0;
    foreach (oq[i]) if (!oq[i].stale) n++;
    return n;
  endfunction

  // One clock: drive memory, compare against model, clock, advance model.
  task automatic step();
    bit m_req, g, rv;
    logic [PC_W-1:0] g_addr;
    logic [OP_W-1:0] rd, e_op;
    logic [PC_W-1:0] e_pc;
    ost_t o;
    mem_drv = (mq.size() > 0) && (mq[0].due <= cyc);
    if (mem_drv) begin
      imem_rvalid = 1'b1; imem_rdata = 16'h1000 + 16'(mq[0].addr);
    end else if (stray) begin
      imem_rvalid = 1'b1; imem_rdata = 16'hBEEF;
    end else begin
      imem_rvalid = 1'b0; imem_rdata = '0;
    end
    #1;
    m_req = !reset && !redirect && (fq.size() + nlive() < DEPTH) && (oq.size() < DEPTH);
    e_op = (fq.size() > 0) ? fq[0].op : '0;
    e_pc = (fq.size() > 0) ? fq[0].pc : '0;
    chk("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("op_valid", 32'(op_valid), 32'(fq.size() != 0));
    chk("op_out", 32'(op_out), 32'(e_op));
    chk("op_pc", 32'(op_pc), 32'(e_pc));
    chk("fifo_count", 32'(fifo_count), 32'(fq.size()));
    g = imem_req && imem_gnt; g_addr = imem_addr; rv = imem_rvalid; rd = imem_rdata;
    @(posedge clk);
    if (reset) begin
      m_pc = 8'h00; oq.delete(); fq.delete(); mq.delete();
    end else begin
      if (mem_drv) void'(mq.pop_front());
      if (g) mq.push_back('{g_addr, cyc + lat});
      if (redirect) begin
        foreach (oq[i]) oq[i].stale = 1'b1;
        if (rv && oq.size() > 0) void'(oq.pop_front());
        fq.delete();
        m_pc = redirect_pc;
      end else begin
        if (fq.size() > 0 && op_ready) void'(fq.pop_front());
        if (rv && oq.size() > 0) begin
          o = oq.pop_front();
          if (!o.stale) fq.push_back('{rd, o.addr});
        end
        if (m_req && imem_gnt) begin
          oq.push_back('{m_pc, 1'b0});
          m_pc++;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_gnt = 1'b0; op_ready = 1'b0; redirect = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    op_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; m_pc = '0;
    @(negedge clk);

    // Streaming at 1-cycle memory latency
    do_reset();
    chk("rst_op_valid", 32'(op_valid), 32'h0);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    chk("rst_op_out", 32'(op_out), 32'h0);
    chk("rst_op_pc", 32'(op_pc), 32'h0);
    imem_gnt = 1'b1; op_ready = 1'b1; lat = 1;
    #1 chk("stream_req", 32'(imem_req), 32'h1);
    chk("stream_addr0", 32'(imem_addr), 32'h0);
    step();
    chk("stream_not_yet", 32'(op_valid), 32'h0);
    step();
    chk("stream_first_valid", 32'(op_valid), 32'h1);
    chk("stream_first_pc", 32'(op_pc), 32'h0);
    chk("stream_first_op", 32'(op_out), 32'h1000);
    for (int i = 1; i < 6; i++) begin
      step();
      chk("stream_pc", 32'(op_pc), 32'(i));
      chk("stream_op", 32'(op_out), 32'h1000 + 32'(i));
    end

    // Backpressure: fill, stall issue, drain
    do_reset();
    imem_gnt = 1'b1; op_ready = 1'b0;
    repeat (6) step();
    chk("bp_full", 32'(fifo_count), 32'h4);
    chk("bp_hold_op", 32'(op_out), 32'h1000);
    #1 chk("bp_req_off", 32'(imem_req), 32'h0);
    op_ready = 1'b1;
    step();
    chk("bp_drain_pc1", 32'(op_pc), 32'h1);
    #1 chk("bp_resume_req", 32'(imem_req), 32'h1);
    chk("bp_resume_addr", 32'(imem_addr), 32'h4);
    repeat (3) step();
    chk("bp_pc4", 32'(op_pc), 32'h4);
    chk("bp_op4", 32'(op_out), 32'h1004);

    // Redirect near the top of the address space: PC wraps
    redirect = 1'b1; redirect_pc = 8'hFE;
    #1 chk("wrap_req_blocked", 32'(imem_req), 32'h0);
    step();
    redirect = 1'b0;
    chk("wrap_flushed", 32'(op_valid), 32'h0);
    step(); step();
    chk("wrap_pc_fe", 32'(op_pc), 32'hFE);
    chk("wrap_op_fe", 32'(op_out), 32'h10FE);
    step();
    chk("wrap_pc_ff", 32'(op_pc), 32'hFF);
    step();
    chk("wrap_pc_00", 32'(op_pc), 32'h00);
    chk("wrap_op_00", 32'(op_out), 32'h1000);
    step();
    chk("wrap_pc_01", 32'(op_pc), 32'h01);

    // Redirect with two requests in flight at 3-cycle latency
    do_reset();
    lat = 3; imem_gnt = 1'b1; op_ready = 1'b1;
    step(); step();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 8'h40;
    step();
    redirect = 1'b0; imem_gnt = 1'b1;
    chk("redir_flushed", 32'(op_valid), 32'h0);
    #1 chk("redir_addr", 32'(imem_addr), 32'h40);
    for (k = 0; k < 10; k++) begin
      step();
      if (op_valid) break;
    end
    chk("redir_latency", 32'(k + 1), 32'h4);
    chk("redir_pc", 32'(op_pc), 32'h40);
    chk("redir_op", 32'(op_out), 32'h1040);
    repeat (3) step();

    // Reset mid-stream, then a stray response
    lat = 1;
    do_reset();
    imem_gnt = 1'b1; op_ready = 1'b0;
    repeat (4) step();
    chk("mid_buffered", 32'(fifo_count), 32'h3);
    reset = 1'b1;
    step();
    reset = 1'b0; imem_gnt = 1'b0;
    chk("mid_rst_valid", 32'(op_valid), 32'h0);
    chk("mid_rst_count", 32'(fifo_count), 32'h0);
    #1 chk("mid_rst_pc", 32'(imem_addr), 32'h0);
    stray = 1'b1;
    step();
    stray = 1'b0;
    chk("stray_no_push", 32'(fifo_count), 32'h0);
    step();

    // Grant, response and pop together at count=2
    do_reset();
    imem_gnt = 1'b1; op_ready = 1'b0;
    repeat (3) step();
    chk("sim_pre_count", 32'(fifo_count), 32'h2);
    op_ready = 1'b1;
    step();
    chk("sim_count", 32'(fifo_count), 32'h2);
    chk("sim_pc1", 32'(op_pc), 32'h1);
    chk("sim_op1", 32'(op_out), 32'h1001);
    step();
    chk("sim_count2", 32'(fifo_count), 32'h2);
    chk("sim_pc2", 32'(op_pc), 32'h2);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
